// File: rtl/alu_writeback.sv
// Register-file write-back stage for the ALU: holds one result set and turns it into
// zero, one or two register-file write strobes (primary result, then secondary to R0).
module alu_writeback #(
  parameter logic [3:0] R0_ADDR = 4'h0,
  parameter int         DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    con,
  input  logic [3:0]    rd,
  input  logic [DW-1:0] result,
  input  logic [DW-1:0] r0_val,
  output logic          wr_en,
  output logic [3:0]    wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR1  = 2'd1,
    WR2  = 2'd2
  } state_t;

  state_t        state_q;
  logic [3:0]    con_q;
  logic [3:0]    rd_q;
  logic [DW-1:0] res_q;
  logic [DW-1:0] r0_q;

  logic xfer;
  logic held_double;
  logic new_writes;

  function automatic logic is_single(input logic [3:0] c);
    return (c == 4'h1) || (c == 4'h2) || (c == 4'hC) || (c == 4'hE) || (c == 4'hF);
  endfunction

  function automatic logic is_double(input logic [3:0] c);
    return (c == 4'h4) || (c == 4'h8);
  endfunction

  // A held double-write must finish its secondary write before anything new is taken.
  assign held_double = is_double(con_q);
  assign in_ready    = !((state_q == WR1) && held_double);
  assign xfer        = in_valid && in_ready;
  assign new_writes  = is_single(con) || is_double(con);
  assign busy        = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      con_q   <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      r0_q    <= '0;
    end else begin
      if (xfer) begin
        con_q <= con;
        rd_q  <= rd;
        res_q <= result;
        r0_q  <= r0_val;
      end
      case (state_q)
        WR1: begin
          if (held_double)
            state_q <= WR2;
          else
            state_q <= (xfer && new_writes) ? WR1 : IDLE;
        end
        default: state_q <= (xfer && new_writes) ? WR1 : IDLE;
      endcase
    end
  end

  // Write port is driven purely from registered state; idle cycles present all zeros.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state_q)
      WR1: begin
        wr_en   = 1'b1;
        wr_addr = rd_q;
        wr_data = res_q;
      end
      WR2: begin
        wr_en   = 1'b1;
        wr_addr = R0_ADDR;
        wr_data = r0_q;
      end
      default: ;
    endcase
  end

  a_dbl_then_wr2: assert property (@(posedge clk) disable iff (rst)
    (state_q == WR1 && held_double) |=> (state_q == WR2));
  a_idle_quiet: assert property (@(posedge clk) disable iff (rst)
    !wr_en |-> (wr_addr == '0 && wr_data == '0));
  a_rst_idle: assert property (@(posedge clk) rst |=> (state_q == IDLE));

endmodule

// File: tb/tb_alu_writeback.sv
// Randomized and directed bench for alu_writeback; a queue of pending register-file
// writes derived from the ALU code classes predicts every write-port cycle.
module tb_alu_writeback;

  localparam int         DW  = 16;
  localparam logic [3:0] R0A = 4'h0;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    con;
  logic [3:0]    rd;
  logic [DW-1:0] result;
  logic [DW-1:0] r0_val;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [3:0]    a;
    logic [DW-1:0] d;
    logic          first_of_two;
  } wr_t;

  wr_t exp_q[$];

  alu_writeback #(.R0_ADDR(R0A), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .con      (con),
    .rd       (rd),
    .result   (result),
    .r0_val   (r0_val),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle, entered and left at a falling edge: check what the write port shows
  // now, present new inputs, advance the model across the next rising edge.
  task automatic cycle(input logic v, input logic [3:0] c, input logic [3:0] r,
                       input logic [DW-1:0] res, input logic [DW-1:0] r0v, input logic rs);
    logic exp_ready;
    exp_ready = (exp_q.size() == 0) || !exp_q[0].first_of_two;
    if (exp_q.size() != 0) begin
      check("wr_en",   {31'd0, wr_en}, 32'd1);
      check("wr_addr", {28'd0, wr_addr}, {28'd0, exp_q[0].a});
      check("wr_data", {16'd0, wr_data}, {16'd0, exp_q[0].d});
    end else begin
      check("idle_wr_en",   {31'd0, wr_en}, 32'd0);
      check("idle_wr_addr", {28'd0, wr_addr}, 32'd0);
      check("idle_wr_data", {16'd0, wr_data}, 32'd0);
    end
    check("busy",     {31'd0, busy}, {31'd0, exp_q.size() != 0});
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});

    in_valid = v;
    con      = c;
    rd       = r;
    result   = res;
    r0_val   = r0v;
    rst      = rs;

    if (exp_q.size() != 0) void'(exp_q.pop_front());
    if (rs) begin
      exp_q.delete();
    end else if (v && exp_ready) begin
      if (c == 4'h4 || c == 4'h8) begin
        exp_q.push_back(wr_t'{a: r, d: res, first_of_two: 1'b1});
        exp_q.push_back(wr_t'{a: R0A, d: r0v, first_of_two: 1'b0});
      end else if (c inside {4'h1, 4'h2, 4'hC, 4'hE, 4'hF}) begin
        exp_q.push_back(wr_t'{a: r, d: res, first_of_two: 1'b0});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 4'h0, 4'h0, '0, '0, 1'b0);
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] rnd2;

    rst = 1'b1; in_valid = 1'b0; con = '0; rd = '0; result = '0; r0_val = '0;
    @(posedge clk);
    @(negedge clk);
    // Held in reset while offering a transfer: must be ignored.
    cycle(1'b1, 4'h1, 4'h9, 16'hAAAA, 16'h5555, 1'b1);
    idle_cycle();

    // Single add
    cycle(1'b1, 4'h1, 4'h3, 16'h1234, 16'hFFFF, 1'b0);
    check("add_data_const", {16'd0, wr_data}, 32'h1234);
    check("add_addr_const", {28'd0, wr_addr}, 32'h3);
    idle_cycle();
    idle_cycle();

    // Multiply: primary then R0 secondary, one bubble of in_ready
    cycle(1'b1, 4'h4, 4'h5, 16'h5678, 16'h0009, 1'b0);
    check("mul_ready_low", {31'd0, in_ready}, 32'd0);
    idle_cycle();
    check("mul_sec_const", {16'd0, wr_data}, 32'h0009);
    idle_cycle();
    idle_cycle();

    // Back-to-back singles
    cycle(1'b1, 4'h1, 4'h1, 16'h0101, 16'h0, 1'b0);
    cycle(1'b1, 4'hE, 4'h2, 16'h0202, 16'h0, 1'b0);
    cycle(1'b1, 4'hC, 4'h3, 16'h0303, 16'h0, 1'b0);
    idle_cycle();
    idle_cycle();

    // Dropped code
    cycle(1'b1, 4'hD, 4'h7, 16'hDEAD, 16'hBEEF, 1'b0);
    idle_cycle();

    // Divide with rd == R0: both writes land on R0, secondary last
    cycle(1'b1, 4'h8, 4'h0, 16'h0004, 16'h0002, 1'b0);
    cycle(1'b1, 4'h1, 4'h9, 16'h0999, 16'h0, 1'b0);  // refused: in_ready low
    idle_cycle();
    idle_cycle();

    // Reset during WR1 of a double-write aborts the secondary
    cycle(1'b1, 4'h4, 4'h5, 16'h1111, 16'h2222, 1'b0);
    cycle(1'b0, 4'h0, 4'h0, '0, '0, 1'b1);
    cycle(1'b1, 4'h2, 4'h6, 16'h0001, 16'h0, 1'b0);
    check("post_rst_data", {16'd0, wr_data}, 32'h0001);
    idle_cycle();

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      rnd  = $urandom();
      rnd2 = $urandom();
      cycle(rnd[0] | rnd[1], rnd[7:4], rnd[11:8], rnd2[15:0], rnd2[31:16],
            (rnd[20:16] == 5'd0));
    end
    idle_cycle();
    idle_cycle();
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
